// File: rtl/vec_mem_responder_if.sv
// Request/response and pixel-RAM bus for vec_mem_responder.
// slave = responder side, master = pipeline + RAM side.
interface vec_mem_responder_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LANES  = 3
);
  logic                     req_valid;
  logic                     req_write;
  logic [LANES-1:0]         req_mask;
  logic [LANES*ADDR_W-1:0]  req_addr;
  logic [LANES*DATA_W-1:0]  req_wdata;
  logic                     req_ready;
  logic                     stall;
  logic                     resp_valid;
  logic [LANES*DATA_W-1:0]  resp_rdata;
  logic                     resp_err;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_mask, req_addr, req_wdata, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_mask, req_addr, req_wdata, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vec_mem_responder.sv
// Serializes a 3-lane vector load/store onto a 1-cycle-latency single-port pixel RAM.
// Optional VMEM_RANGE_CHECK_EN: drop lanes with addr >= MEM_DEPTH and flag resp_err.
module vec_mem_responder #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LANES     = 3,
  parameter int unsigned MEM_DEPTH = 1000
) (
  input logic               CLK,
  input logic               RST,
  vec_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StResp} state_e;

  state_e                    r_state, w_state_next;
  logic [1:0]                r_lane;
  logic                      r_write;
  logic [LANES-1:0]          r_mask;
  logic [LANES*ADDR_W-1:0]   r_addr;
  logic [LANES*DATA_W-1:0]   r_wdata;
  logic [LANES*DATA_W-1:0]   r_rdata;
  logic                      r_err;
  logic                      r_cap_valid;
  logic [1:0]                r_cap_lane;

  logic [LANES-1:0]          w_oob;
  logic [LANES-1:0]          w_in_mask;
  logic                      w_err;
  logic [1:0]                w_first;
  logic [1:0]                w_next;
  logic                      w_has_next;
  logic                      w_issue;

  always_comb begin
    w_oob = '0;
    for (int k = 0; k < LANES; k++) begin
      w_oob[k] = 32'(bus.req_addr[k*ADDR_W +: ADDR_W]) >= MEM_DEPTH;
    end
  end

`ifdef VMEM_RANGE_CHECK_EN
  assign w_in_mask = bus.req_mask & ~w_oob;
  assign w_err     = |(bus.req_mask & w_oob);
`else
  logic w_unused;
  assign w_in_mask = bus.req_mask;
  assign w_err     = 1'b0;
  assign w_unused  = |w_oob;
`endif

  // Descending scans so the lowest qualifying lane wins.
  always_comb begin
    w_first = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (w_in_mask[k]) w_first = 2'(k);
    end
  end

  always_comb begin
    w_next     = '0;
    w_has_next = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (r_mask[k] && (k > int'(r_lane))) begin
        w_next     = 2'(k);
        w_has_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) w_state_next = (w_in_mask == '0) ? StResp : StIssue;
      end
      StIssue: begin
        if (!w_has_next) w_state_next = r_write ? StResp : StDrain;
      end
      StDrain: w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lane      <= '0;
      r_write     <= 1'b0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_lane  <= '0;
    end else begin
      // Read data of the lane issued last cycle lands now.
      if (r_cap_valid) r_rdata[r_cap_lane*DATA_W +: DATA_W] <= bus.mem_rdata;
      r_cap_valid <= (r_state == StIssue) && !r_write;
      r_cap_lane  <= r_lane;
      if (r_state == StIdle && bus.req_valid) begin
        r_write <= bus.req_write;
        r_mask  <= w_in_mask;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_err;
        r_rdata <= '0;
        r_lane  <= w_first;
      end else if (r_state == StIssue && w_has_next) begin
        r_lane <= w_next;
      end
    end
  end

  assign w_issue        = (r_state == StIssue);
  assign bus.req_ready  = (r_state == StIdle);
  assign bus.stall      = ((r_state == StIdle) && bus.req_valid) || w_issue ||
                          (r_state == StDrain);
  assign bus.resp_valid = (r_state == StResp);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = (r_state == StResp) && r_err;
  assign bus.mem_en     = w_issue;
  assign bus.mem_we     = w_issue && r_write;
  assign bus.mem_addr   = w_issue ? r_addr[r_lane*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_wdata  = w_issue ? r_wdata[r_lane*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder with a behavioural 1-cycle pixel RAM.
module tb_vec_mem_responder;
  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [17:0] ram [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [17:0] pre_d  = '0;

  vec_mem_responder_if bus ();

  vec_mem_responder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      else                     bus.mem_rdata <= ram[bus.mem_addr];
    end else if (pre_we) begin
      ram[pre_a] <= pre_d;
    end
  end

  task automatic preload(input logic [9:0] a, input logic [17:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  // Drives one request, waits for acceptance, and records what the DUT did up to resp_valid.
  task automatic run_req(input logic w, input logic [2:0] m, input logic [29:0] a,
                         input logic [53:0] wd, output int o_wait, output int o_lat,
                         output int o_n, output logic [29:0] o_iss, output logic [53:0] o_rd,
                         output logic o_err, output logic [15:0] o_stall);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_mask  = m;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    o_wait = 0; o_lat = 0; o_n = 0; o_iss = '0; o_rd = '0; o_err = 1'b0; o_stall = '0;
    #1;
    while (bus.req_ready !== 1'b1 && o_wait < 10) begin
      @(posedge CLK); #1;
      o_wait++;
    end
    o_stall[0] = bus.stall;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      o_stall[c] = bus.stall;
      if (bus.mem_en === 1'b1) begin
        if (o_n < 3) o_iss[o_n*10 +: 10] = bus.mem_addr;
        o_n++;
      end
      if (bus.resp_valid === 1'b1) begin
        o_lat = c;
        o_rd  = bus.resp_rdata;
        o_err = bus.resp_err;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    logic seen;
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.stall, bus.resp_valid, bus.resp_err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1000",
               {bus.req_ready, bus.stall, bus.resp_valid, bus.resp_err});
    end
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: mem_en=%b mem_addr=%h rdata=%h want all 0",
               bus.mem_en, bus.mem_addr, bus.resp_rdata);
    end
    preload(10'd5, 18'h00011);
    preload(10'd6, 18'h00022);
    preload(10'd485, 18'h3FFFF);
    preload(10'd21, 18'h00155);
    preload(10'd30, 18'h12345);
    preload(10'd1, 18'h00101);
    preload(10'd2, 18'h00202);
    preload(10'd1000, 18'h002AA);
    RST = 1'b0;
    @(posedge CLK); #1;
    // Mid-ISSUE abort on lane 1.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_mask  = 3'b111;
    bus.req_addr  = {10'd485, 10'd6, 10'd5};
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'd6}) begin
      n_bad++;
      $display("FAIL reset_pre_lane1: got en=%b addr=%0d want en=1 addr=6",
               bus.mem_en, bus.mem_addr);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_en, bus.req_ready, bus.stall} !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_abort: got en/ready/stall=%b want 010",
               {bus.mem_en, bus.req_ready, bus.stall});
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      seen |= bus.resp_valid;
    end
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      seen |= bus.resp_valid | bus.mem_en;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_resp: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_full_load();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b0, 3'b111, {10'd485, 10'd6, 10'd5}, '0, wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL load_latency: got %0d want 5", lat); end
    n_cmp++;
    if (iss !== {10'd485, 10'd6, 10'd5} || n !== 3) begin
      n_bad++;
      $display("FAIL load_issue: got n=%0d addrs=%h want 3 addrs=%h", n, iss,
               {10'd485, 10'd6, 10'd5});
    end
    n_cmp++;
    if (rd !== {18'h3FFFF, 18'h00022, 18'h00011}) begin
      n_bad++;
      $display("FAIL load_rdata: got %h want %h", rd, {18'h3FFFF, 18'h00022, 18'h00011});
    end
    n_cmp++;
    if (st[5:0] !== 6'b011111) begin
      n_bad++;
      $display("FAIL load_stall: got %b want 011111", st[5:0]);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", err); end
  endtask

  task automatic test_masked_load();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b0, 3'b010, {10'd5, 10'd30, 10'd6}, '0, wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (lat !== 3 || n !== 1 || iss[9:0] !== 10'd30) begin
      n_bad++;
      $display("FAIL mload_issue: got lat=%0d n=%0d addr=%0d want 3 1 30", lat, n, iss[9:0]);
    end
    n_cmp++;
    if (rd !== {18'h0, 18'h12345, 18'h0}) begin
      n_bad++;
      $display("FAIL mload_rdata: got %h want %h", rd, {18'h0, 18'h12345, 18'h0});
    end
  endtask

  task automatic test_masked_store();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b1, 3'b101, {10'd20, 10'd21, 10'd22}, {18'h1, 18'h2, 18'h3},
            wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (lat !== 3 || n !== 2 || iss !== {10'd0, 10'd20, 10'd22}) begin
      n_bad++;
      $display("FAIL mstore_issue: got lat=%0d n=%0d addrs=%h want 3 2 %h", lat, n, iss,
               {10'd0, 10'd20, 10'd22});
    end
    n_cmp++;
    if ({ram[20], ram[21], ram[22]} !== {18'h1, 18'h155, 18'h3}) begin
      n_bad++;
      $display("FAIL mstore_ram: got %h %h %h want 1 155 3", ram[20], ram[21], ram[22]);
    end
    n_cmp++;
    if (st[3:0] !== 4'b0111) begin
      n_bad++;
      $display("FAIL mstore_stall: got %b want 0111", st[3:0]);
    end
  endtask

  task automatic test_dup_store();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b1, 3'b111, {10'd7, 10'd7, 10'd7}, {18'hA, 18'hB, 18'hC},
            wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (lat !== 4 || n !== 3) begin
      n_bad++;
      $display("FAIL dup_latency: got lat=%0d n=%0d want 4 3", lat, n);
    end
    n_cmp++;
    if (ram[7] !== 18'hA) begin
      n_bad++;
      $display("FAIL dup_ram: got %h want 0000a", ram[7]);
    end
  endtask

  task automatic test_back_to_back();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b0, 3'b000, {10'd5, 10'd6, 10'd7}, '0, wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (lat !== 1 || n !== 0 || rd !== '0) begin
      n_bad++;
      $display("FAIL zero_mask: got lat=%0d n=%0d rdata=%h want 1 0 0", lat, n, rd);
    end
    n_cmp++;
    if ({bus.req_ready, bus.stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL resp_ready_stall: got %b want 00", {bus.req_ready, bus.stall});
    end
    run_req(1'b0, 3'b000, '0, '0, wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (wt !== 1 || lat !== 1) begin
      n_bad++;
      $display("FAIL b2b_zero: got wait=%0d lat=%0d want 1 1", wt, lat);
    end
    run_req(1'b1, 3'b111, {10'd42, 10'd41, 10'd40}, {18'h3, 18'h2, 18'h1},
            wt, lat, n, iss, rd, err, st);
    n_cmp++;
    if (wt !== 1 || lat !== 4) begin
      n_bad++;
      $display("FAIL b2b_store: got wait=%0d lat=%0d want 1 4", wt, lat);
    end
    n_cmp++;
    if ({ram[40], ram[41], ram[42]} !== {18'h1, 18'h2, 18'h3}) begin
      n_bad++;
      $display("FAIL b2b_ram: got %h %h %h want 1 2 3", ram[40], ram[41], ram[42]);
    end
  endtask

  task automatic test_range();
    int wt, lat, n; logic [29:0] iss; logic [53:0] rd; logic err; logic [15:0] st;
    run_req(1'b0, 3'b111, {10'd1000, 10'd2, 10'd1}, '0, wt, lat, n, iss, rd, err, st);
`ifdef VMEM_RANGE_CHECK_EN
    n_cmp++;
    if (n !== 2 || lat !== 4 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_issue: got n=%0d lat=%0d err=%b want 2 4 1", n, lat, err);
    end
    n_cmp++;
    if (rd !== {18'h0, 18'h202, 18'h101}) begin
      n_bad++;
      $display("FAIL range_rdata: got %h want %h", rd, {18'h0, 18'h202, 18'h101});
    end
`else
    n_cmp++;
    if (n !== 3 || lat !== 5 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL range_issue: got n=%0d lat=%0d err=%b want 3 5 0", n, lat, err);
    end
    n_cmp++;
    if (rd !== {18'h2AA, 18'h202, 18'h101}) begin
      n_bad++;
      $display("FAIL range_rdata: got %h want %h", rd, {18'h2AA, 18'h202, 18'h101});
    end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_mask  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_full_load();
    test_masked_load();
    test_masked_store();
    test_dup_store();
    test_back_to_back();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the filter GPU pipeline's memory stage.
- Accepts one 3-lane vector load/store request per handshake: three pixel addresses, three 18-bit lane data words, and a lane mask.
- Serializes the request onto a single-port, 1-cycle-latency pixel RAM, one lane per cycle.
- Returns the gathered lane data and drives a stall that freezes the upstream pipeline buffers while the access is in flight.

Parameters:
- DATA_W, 18, lane data width.
- ADDR_W, 10, pixel address width.
- LANES, 3, lanes per vector request.
- MEM_DEPTH, 1000, number of valid RAM words; used only by the optional feature.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory stage holds a load/store request.
- req_write  in  1  1 = store, 0 = load.
- req_mask  in  LANES  per-lane enable; bit k gates lane k.
- req_addr  in  LANES*ADDR_W  lane k address at [k*ADDR_W +: ADDR_W].
- req_wdata  in  LANES*DATA_W  lane k store data at [k*DATA_W +: DATA_W].
- req_ready  out  1  request accepted this cycle if req_valid is also high.
- stall  out  1  freeze upstream pipeline buffers (to the fetch, instruction and ALU buffer enables).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  LANES*DATA_W  gathered load data, stable while resp_valid is high.
- resp_err  out  1  out-of-range flag, qualified by resp_valid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after an mem_en=1, mem_we=0 access.

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, RESP. A 2-bit lane counter and registered copies of all req_* fields are held.
- Reset (asynchronous, immediate):
  - State IDLE, lane counter 0, captured registers 0, resp_rdata 0.
  - All mem_* outputs 0.
  - resp_valid=0, resp_err=0, req_ready=1, stall=0 (req_valid low).
  - Reset during ISSUE aborts immediately; mem_en drops with RST, not at the next edge.
- req_ready = (state==IDLE).
- stall = (state==IDLE && req_valid) || state==ISSUE || state==DRAIN. stall is 0 in RESP, so the pipeline advances on the RESP edge.
- IDLE: on req_valid, capture the request, clear resp_rdata, set lane counter to the lowest set mask bit, and go to ISSUE. If req_mask==0, go directly to RESP.
- ISSUE:
  - mem_en=1, mem_we=req_write, mem_addr=addr[lane], mem_wdata=wdata[lane]; all combinational from registered state.
  - Each cycle the lane counter advances to the next set mask bit. Masked lanes consume no cycle.
  - After the last enabled lane: a load goes to DRAIN, a store goes to RESP.
- Load data capture: for each load lane issued in cycle t, capture mem_rdata in cycle t+1 into resp_rdata lane k. This capture overlaps the next ISSUE cycle or DRAIN.
- DRAIN: captures the final lane; mem_en=0; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A request is never re-accepted in RESP, because req_ready=0.
- Latency, full mask, request accepted on edge T:
  - Load: ISSUE at T+1..T+3, DRAIN at T+4, resp_valid at T+5.
  - Store: resp_valid at T+4.
- Lanes with mask 0 read back as 0.
- Duplicate store addresses: lanes are issued in ascending order, so the highest-numbered lane wins.
- Loads see RAM contents as of their issue cycle.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: VMEM_RANGE_CHECK_EN.
- Defined:
  - An enabled lane with addr >= MEM_DEPTH is treated as masked: not issued, reads back 0.
  - resp_err=1 during RESP if any enabled lane was out of range.
- Undefined:
  - Every enabled lane is issued unchanged.
  - resp_err is tied to 0.

Test Plan:
- Reset: assert RST mid-ISSUE on lane 1 -> mem_en=0 in the same cycle, state IDLE, resp_valid never pulses; the next request completes normally.
- Full load: RAM[5]=0x00011, RAM[6]=0x00022, RAM[485]=0x3FFFF; load mask 3'b111, addrs {485,6,5} -> mem_addr 5, 6, 485 at T+1..T+3; resp_valid at T+5; resp_rdata={0x3FFFF,0x00022,0x00011}; stall high T..T+4, low T+5.
- Masked store: mask 3'b101, addrs {20,21,22}, wdata {0x1,0x2,0x3} -> two write cycles (addr 22 then 20), RAM[21] untouched, resp_valid at T+3.
- Duplicate store: all lanes addr 7, wdata {0xA,0xB,0xC} -> RAM[7]=0xA (lane 2 written last).
- Zero mask load -> no mem_en, resp_valid at T+1, resp_rdata=0; back-to-back requests each accepted in the cycle after RESP.
- With VMEM_RANGE_CHECK_EN: load addrs {1000,2,1}, mask 3'b111 -> only 2 issues, lane 2 reads 0, resp_err=1. Without the macro: 3 issues, resp_err=0.
